// File: rtl/ls_shift_reg.sv
// ls_shift_reg: parametrised multi-mode shift register with parallel load.
//
// One register serves both parallel capture (c/in) and multi-cycle bit-serial
// shifting. A two-state FSM (StIdle/StRun) driven by a down-counter performs
// `amt` single-bit shifts, one per clock, with a busy/done handshake.
//
// Parameters:
//   N    data width in bits (N >= 2)
//   SHW  shift-amount width (2**SHW >= N)
//
// Ports:
//   clk    clock, rising edge
//   clr    synchronous active-high reset
//   c      parallel load enable (wins over start / shifting, aborts a run)
//   in     parallel load data
//   start  begin shift operation (sampled only in idle)
//   op     00 shift left, 01 logical right, 10 arithmetic right, 11 rotate left
//   amt    number of single-bit shifts
//   sin    serial input bit, sampled live on every shift edge
//   out    register contents
//   sout   last bit shifted out (registered)
//   busy   high while a shift operation is in progress
//   done   one-cycle completion pulse
//
// Build option:
//   LS_SHIFT_REG_ROTATE_EN  when defined, op=11 rotates left; otherwise op=11
//                           is a plain shift left with sin.

module ls_shift_reg #(
   parameter int unsigned N   = 8,
   parameter int unsigned SHW = 3
) (
   input  logic           clk,
   input  logic           clr,
   input  logic           c,
   input  logic [N-1:0]   in,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [SHW-1:0] amt,
   input  logic           sin,
   output logic [N-1:0]   out,
   output logic           sout,
   output logic           busy,
   output logic           done
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   out_q, out_d;
   logic           sout_q, sout_d;
   logic           done_q, done_d;
   logic [SHW-1:0] cnt_q, cnt_d;
   logic [1:0]     op_q, op_d;

   logic [N-1:0]   shift_val;
   logic           shift_bit;

   // Single-bit shift of the current contents using the latched op.
   always_comb begin
      shift_val = out_q;
      shift_bit = sout_q;
      case (op_q)
         2'b01: begin
            shift_val = {sin, out_q[N-1:1]};
            shift_bit = out_q[0];
         end
         2'b10: begin
            shift_val = {out_q[N-1], out_q[N-1:1]};
            shift_bit = out_q[0];
         end
`ifdef LS_SHIFT_REG_ROTATE_EN
         2'b11: begin
            shift_val = {out_q[N-2:0], out_q[N-1]};
            shift_bit = out_q[N-1];
         end
`endif
         // 00, and 11 when rotate is not built in.
         default: begin
            shift_val = {out_q[N-2:0], sin};
            shift_bit = out_q[N-1];
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      sout_d  = sout_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      op_d    = op_q;

      if (c) begin
         // Load aborts any run without a done pulse.
         out_d   = in;
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  if (amt != '0) begin
                     op_d    = op;
                     cnt_d   = amt;
                     state_d = StRun;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            StRun: begin
               out_d  = shift_val;
               sout_d = shift_bit;
               cnt_d  = cnt_q - SHW'(1);
               if (cnt_q == SHW'(1)) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= StIdle;
         out_q   <= '0;
         sout_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         op_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         sout_q  <= sout_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   assign out  = out_q;
   assign sout = sout_q;
   assign busy = (state_q == StRun);
   assign done = done_q;

endmodule

// File: tb/tb_ls_shift_reg.sv
// Directed bench for ls_shift_reg (N=8, SHW=4 so amounts above N are reachable).
// Expected shift results are pushed to a scoreboard when a shift is started and
// popped when the done pulse appears.

module tb_ls_shift_reg;

   localparam int unsigned N   = 8;
   localparam int unsigned SHW = 4;

   logic           clk = 1'b0;
   logic           clr, c, start, sin;
   logic [N-1:0]   d_in;
   logic [1:0]     op;
   logic [SHW-1:0] amt;
   logic [N-1:0]   out;
   logic           sout, busy, done;

   typedef struct {
      string      tag;
      logic [7:0] out;
      logic       sout;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   ls_shift_reg #(.N(N), .SHW(SHW)) dut (
      .clk   (clk),
      .clr   (clr),
      .c     (c),
      .in    (d_in),
      .start (start),
      .op    (op),
      .amt   (amt),
      .sin   (sin),
      .out   (out),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Optionally loads init, starts a shift of a>0 steps, waits for done and
   // compares against the scoreboard entry.
   task automatic run_shift(input string tag, input bit do_load, input logic [7:0] init,
                            input logic [1:0] o, input int a, input logic s,
                            input logic [7:0] exp_out, input logic exp_sout);
      exp_t e;
      int   cycles;
      int   busy_cnt;
      if (do_load) begin
         c = 1'b1; d_in = init;
         tick();
         c = 1'b0;
      end
      op = o; amt = SHW'(a); sin = s; start = 1'b1;
      tick();
      start = 1'b0;
      e.tag = tag; e.out = exp_out; e.sout = exp_sout;
      sb.push_back(e);
      // Scramble op/amt: the latched copies must be used.
      op = ~o; amt = '1;
      check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      check({tag, "_done0"}, {31'd0, done}, 32'd0);
      cycles = 0; busy_cnt = 0;
      while (done !== 1'b1 && cycles < 40) begin
         if (busy === 1'b1) busy_cnt++;
         tick();
         cycles++;
      end
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_lat"}, cycles, a);
      check({tag, "_busycyc"}, busy_cnt, a);
      check({tag, "_busyoff"}, {31'd0, busy}, 32'd0);
      e = sb.pop_front();
      check({e.tag, "_out"}, {24'd0, out}, {24'd0, e.out});
      check({e.tag, "_sout"}, {31'd0, sout}, {31'd0, e.sout});
   endtask

   initial begin
      clr = 1'b1; c = 1'b0; start = 1'b0; sin = 1'b0;
      d_in = '0; op = 2'b00; amt = '0;
      tick();
      check("rst_out", {24'd0, out}, 32'h00);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sout", {31'd0, sout}, 32'd0);
      clr = 1'b0;

      c = 1'b1; d_in = 8'hA5;
      tick();
      c = 1'b0;
      check("load_out", {24'd0, out}, 32'hA5);
      check("load_done", {31'd0, done}, 32'd0);
      tick();
      check("idle_hold", {24'd0, out}, 32'hA5);

      run_shift("shl", 1'b1, 8'h81, 2'b00, 3, 1'b1, 8'h0F, 1'b0);
      tick();
      check("shl_pulse", {31'd0, done}, 32'd0);
      run_shift("asr", 1'b1, 8'h90, 2'b10, 2, 1'b1, 8'hE4, 1'b0);
      run_shift("lsr", 1'b1, 8'h90, 2'b01, 2, 1'b0, 8'h24, 1'b0);
`ifdef LS_SHIFT_REG_ROTATE_EN
      run_shift("rot", 1'b1, 8'h81, 2'b11, 1, 1'b0, 8'h03, 1'b1);
`else
      run_shift("rot", 1'b1, 8'h81, 2'b11, 1, 1'b0, 8'h02, 1'b1);
`endif
      run_shift("shl_big", 1'b1, 8'h00, 2'b00, 10, 1'b1, 8'hFF, 1'b1);
      run_shift("asr_big", 1'b1, 8'h80, 2'b10, 12, 1'b0, 8'hFF, 1'b1);

      // Abort by load: stray start ignored, load on edge 2.
      c = 1'b1; d_in = 8'h55;
      tick();
      c = 1'b0; op = 2'b00; amt = SHW'(5); sin = 1'b1; start = 1'b1;
      tick();
      check("abort_busy", {31'd0, busy}, 32'd1);
      tick();
      start = 1'b0;
      check("abort_busy1", {31'd0, busy}, 32'd1);
      c = 1'b1; d_in = 8'h3C;
      tick();
      c = 1'b0;
      check("abort_out", {24'd0, out}, 32'h3C);
      check("abort_busyoff", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      tick();
      check("abort_done1", {31'd0, done}, 32'd0);
      check("abort_hold", {24'd0, out}, 32'h3C);

      // Reset mid-run.
      amt = SHW'(5); start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_out", {24'd0, out}, 32'h00);
      check("clr_sout", {31'd0, sout}, 32'd0);
      check("clr_busy", {31'd0, busy}, 32'd0);
      check("clr_done", {31'd0, done}, 32'd0);
      tick();
      check("clr_done1", {31'd0, done}, 32'd0);

      // amt=0 then back-to-back start in the done cycle.
      c = 1'b1; d_in = 8'h5A;
      tick();
      c = 1'b0; amt = '0; start = 1'b1;
      tick();
      start = 1'b0;
      check("z_done", {31'd0, done}, 32'd1);
      check("z_busy", {31'd0, busy}, 32'd0);
      check("z_out", {24'd0, out}, 32'h5A);
      run_shift("b2b", 1'b0, 8'h00, 2'b01, 2, 1'b1, 8'hD6, 1'b1);
      tick();
      check("b2b_pulse", {31'd0, done}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
